// File: rtl/mc_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The master modport is the sequencer; the slave side is the datapath/IR/memory.
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control sequencer (Moore FSM with memory-ready stalls).
// Define ADDI_EN to add the addi execute/writeback path (states 10 and 11).
module mc_control_fsm (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
`ifdef ADDI_EN
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] decode_state;
  logic       opcode_legal;

  always_comb begin
    opcode_legal = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: opcode_legal = 1'b1;
`ifdef ADDI_EN
      OP_ADDI:                              opcode_legal = 1'b1;
`endif
      default:                              opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
        else                          state_d = S_FETCH;
      end
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
`ifdef ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // While reset is held, outputs decode as FETCH regardless of the register.
  assign decode_state = rst_n ? state_q : S_FETCH;
  assign bus.state    = state_q;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    case (decode_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready & rst_n;
        bus.pc_write  = bus.mem_ready & rst_n;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.illegal_op = ~opcode_legal;
        bus.instr_done = ~opcode_legal;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
      end
`ifdef ADDI_EN
      S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main control sequencer for the MIPS datapath. Decodes the instruction opcode over a fixed sequence of states and drives every datapath enable and mux select, including the 2-bit ALU operation class consumed by the ALU control decoder (00 add, 01 subtract, 10 use funct). It sits between the instruction register and the datapath, and stalls on a memory ready handshake.

## Interface
Parameters:
- None.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous reset, active low
- opcode  input  6  instr[31:26] from the instruction register; stable from DECODE until instruction retire
- mem_ready  input  1  memory has completed the current read or write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 rt, 1 rd
- mem_to_reg  output  1  write data: 0 ALUOut, 1 MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- alu_op  output  2  ALU operation class to the ALU control decoder
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  4  current state encoding, for debug

## Operation
- Moore FSM. All outputs decode from the state register, except where noted below. Every output not listed for a state is 0.
- FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 (R-type) -> R_EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EXEC, only when the macro is enabled
  - anything else -> FETCH, with illegal_op=1 and instr_done=1 in this cycle
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next is FETCH.
- MEM_WRITE (5): mem_write=1, i_or_d=1. Holds until mem_ready=1, then -> FETCH; instr_done=1 in that same cycle.
- R_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next is FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next is FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1. Next is FETCH.
- ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDI_WB.
- ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next is FETCH.
- Unused encodings 12-15 go to FETCH on the next edge. All outputs are 0 in those states.

## Timing
- Reset: rst_n sampled low at a rising edge sets state=FETCH.
  - While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0.
  - Other outputs show FETCH values.
- Reset mid-instruction aborts it: no write strobe is issued, and the FSM restarts at FETCH.
- Cycles per instruction with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored in every other state.
- The opcode input is sampled only in DECODE and MEM_ADDR.

## Configuration
- ADDI_EN defined: opcode 001000 follows the ADDI_EXEC/ADDI_WB path.
- ADDI_EN undefined: states 10-11 are not generated, and 001000 is treated as illegal (illegal_op pulse in DECODE, then FETCH).

## Test plan
- Reset, zero-wait: rst_n=0 for 2 cycles, then 1 with mem_ready=1.
  - state=0 during reset, with pc_write=0 and ir_write=0.
  - First post-reset cycle: mem_read=1, ir_write=1, pc_write=1.
- R-type, opcode=000000, mem_ready=1:
  - state sequence 0,1,6,7,0.
  - alu_op=10 in state 6.
  - reg_write=1 and reg_dst=1 only in state 7, with instr_done=1 there.
- lw with 2 wait cycles in MEM_READ, opcode=100011:
  - state sequence 0,1,2,3,3,3,4,0.
  - mem_read=1 and i_or_d=1 for all three state-3 cycles.
  - reg_write=1 and mem_to_reg=1 in state 4.
- sw with a FETCH stall of 1 cycle, then beq:
  - sw sequence 0,0,1,2,5,0, with mem_write=1 only in state 5.
  - beq sequence 1,8 with alu_op=01, pc_write_cond=1, pc_source=01.
- Opcode 111111 and opcode 001000 with ADDI_EN undefined:
  - each gives illegal_op=1 in DECODE, then state 0, with no write strobes.
  - With ADDI_EN defined, 001000 gives 1,10,11,0 and reg_write=1 in state 11.
- rst_n=0 asserted while in MEM_READ with mem_ready=0:
  - next state is 0, with no reg_write pulse.
  - j (000010) afterwards gives 0,1,9 with pc_write=1 and pc_source=10.
